// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler_if
//  Description : Bundle of every non-clock/reset signal around the issue
//                scheduler: global control, instruction-queue head,
//                decoder loop-back, ROB/RS/LSB dispatch and statistics.
//                modport master : the scheduler itself
//                modport slave  : queue, decoder and back end around it
//  Revision    : 1.0 - initial release
// ============================================================================
interface issue_scheduler_if #(
  parameter int OPE_W  = 6,
  parameter int REGN_W = 6,
  parameter int ROB_W  = 4
);
  // global control
  logic              rdy_in;
  logic              flush_in;
  // instruction queue head
  logic              iq_valid_in;
  logic [31:0]       iq_code_in;
  logic [31:0]       iq_pc_in;
  logic              iq_pred_in;
  logic              iq_pop_out;
  // decoder loop
  logic [31:0]       dec_code_out;
  logic [31:0]       dec_pc_out;
  logic [OPE_W-1:0]  dec_type_in;
  logic [REGN_W-1:0] dec_rd_in;
  logic [REGN_W-1:0] dec_rs1_in;
  logic [REGN_W-1:0] dec_rs2_in;
  logic [31:0]       dec_imm_in;
  // back end status
  logic              rob_ready_in;
  logic [ROB_W-1:0]  rob_tag_in;
  logic              rs_ready_in;
  logic              lsb_ready_in;
  // dispatch
  logic              rob_alloc_out;
  logic              rs_issue_out;
  logic              lsb_issue_out;
  logic [OPE_W-1:0]  iss_type_out;
  logic [REGN_W-1:0] iss_rd_out;
  logic [REGN_W-1:0] iss_rs1_out;
  logic [REGN_W-1:0] iss_rs2_out;
  logic [31:0]       iss_imm_out;
  logic [31:0]       iss_pc_out;
  logic              iss_pred_out;
  logic [ROB_W-1:0]  iss_tag_out;
  logic              rob_ready_res_out;
  logic [31:0]       rob_res_out;
  // status / statistics
  logic              illegal_out;
  logic [31:0]       stat_issued_out;
  logic [31:0]       stat_stall_out;

  modport master (
    input  rdy_in, flush_in,
    input  iq_valid_in, iq_code_in, iq_pc_in, iq_pred_in,
    output iq_pop_out,
    output dec_code_out, dec_pc_out,
    input  dec_type_in, dec_rd_in, dec_rs1_in, dec_rs2_in, dec_imm_in,
    input  rob_ready_in, rob_tag_in, rs_ready_in, lsb_ready_in,
    output rob_alloc_out, rs_issue_out, lsb_issue_out,
    output iss_type_out, iss_rd_out, iss_rs1_out, iss_rs2_out,
    output iss_imm_out, iss_pc_out, iss_pred_out, iss_tag_out,
    output rob_ready_res_out, rob_res_out,
    output illegal_out, stat_issued_out, stat_stall_out
  );

  modport slave (
    output rdy_in, flush_in,
    output iq_valid_in, iq_code_in, iq_pc_in, iq_pred_in,
    input  iq_pop_out,
    input  dec_code_out, dec_pc_out,
    output dec_type_in, dec_rd_in, dec_rs1_in, dec_rs2_in, dec_imm_in,
    output rob_ready_in, rob_tag_in, rs_ready_in, lsb_ready_in,
    input  rob_alloc_out, rs_issue_out, lsb_issue_out,
    input  iss_type_out, iss_rd_out, iss_rs1_out, iss_rs2_out,
    input  iss_imm_out, iss_pc_out, iss_pred_out, iss_tag_out,
    input  rob_ready_res_out, rob_res_out,
    input  illegal_out, stat_issued_out, stat_stall_out
  );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler
//  Description : Issue-stage sequencer. Pops the instruction-queue head,
//                loops it through the combinational RV32I decoder, latches
//                the decoded fields into a one-entry hold register and
//                dispatches to ROB + RS (ALU/branch/JALR) or ROB + LSB
//                (loads/stores) under per-unit back-pressure.
//                LUI/AUIPC/JAL only allocate a ROB entry with a precomputed
//                result. Handles flush, illegal-instruction stop and the
//                global rdy freeze.
//  Ports       : clk_in  - clock
//                rst_in  - asynchronous active-low reset
//                bus     - issue_scheduler_if.master (queue, decoder,
//                          back end, status and statistics signals)
//  Options     : ISSUE_STAT_EN - when defined, builds the issued/stall
//                statistics counters; otherwise both read constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
  parameter int OPE_W      = 6,
  parameter int REGN_W     = 6,
  parameter int ROB_W      = 4,
  parameter int EMPTY_TYPE = 0
) (
  input wire                clk_in,
  input wire                rst_in,
  issue_scheduler_if.master bus
);

  localparam logic [OPE_W-1:0] c_empty_type = OPE_W'(EMPTY_TYPE);
  localparam logic [6:0]       c_op_load    = 7'h03;
  localparam logic [6:0]       c_op_store   = 7'h23;
  localparam logic [6:0]       c_op_lui     = 7'h37;
  localparam logic [6:0]       c_op_auipc   = 7'h17;
  localparam logic [6:0]       c_op_jal     = 7'h6F;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_STOP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [6:0]        r_op;
  logic [31:0]       r_pc;
  logic              r_pred;
  logic [OPE_W-1:0]  r_type;
  logic [REGN_W-1:0] r_rd;
  logic [REGN_W-1:0] r_rs1;
  logic [REGN_W-1:0] r_rs2;
  logic [31:0]       r_imm;

  logic w_hold_v;
  logic w_illegal;
  logic w_is_mem;
  logic w_is_direct;
  logic w_unit_rdy;
  logic w_fire;
  logic w_pop;
  logic w_latch;

  assign w_hold_v    = (r_state == ST_HELD);
  assign w_illegal   = (r_state == ST_STOP);
  assign w_is_mem    = (r_op == c_op_load) || (r_op == c_op_store);
  assign w_is_direct = (r_op == c_op_lui) || (r_op == c_op_auipc) || (r_op == c_op_jal);
  // Direct-result instructions only need a ROB entry.
  assign w_unit_rdy  = w_is_mem ? bus.lsb_ready_in :
                       w_is_direct ? 1'b1 : bus.rs_ready_in;
  assign w_fire      = w_hold_v & bus.rdy_in & ~bus.flush_in & bus.rob_ready_in & w_unit_rdy;
  // The slot can be refilled in the same cycle it drains: no bubble.
  assign w_pop       = bus.rdy_in & ~bus.flush_in & ~w_illegal & bus.iq_valid_in &
                       (~w_hold_v | w_fire);
  // An unrecognised instruction is consumed but never enters the slot.
  assign w_latch     = w_pop & (bus.dec_type_in != c_empty_type);

  // --------------------------------------------------------------------------
  // Hold-register state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.iq_pop_out    = w_pop;
    bus.rob_alloc_out = w_fire;
    bus.rs_issue_out  = w_fire & ~w_is_mem & ~w_is_direct;
    bus.lsb_issue_out = w_fire & w_is_mem;
    bus.illegal_out   = w_illegal;
    if (bus.rdy_in) begin
      if (bus.flush_in) begin
        // Flush empties the slot but never leaves the stopped state.
        if (r_state == ST_HELD) begin
          w_state_nxt = ST_EMPTY;
        end
      end else if (w_pop) begin
        w_state_nxt = w_latch ? ST_HELD : ST_STOP;
      end else if (w_fire) begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Held instruction fields
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_op   <= '0;
      r_pc   <= '0;
      r_pred <= 1'b0;
      r_type <= '0;
      r_rd   <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_imm  <= '0;
    end else if (w_latch) begin
      r_op   <= bus.iq_code_in[6:0];
      r_pc   <= bus.iq_pc_in;
      r_pred <= bus.iq_pred_in;
      r_type <= bus.dec_type_in;
      r_rd   <= bus.dec_rd_in;
      r_rs1  <= bus.dec_rs1_in;
      r_rs2  <= bus.dec_rs2_in;
      r_imm  <= bus.dec_imm_in;
    end
  end

  assign bus.dec_code_out = bus.iq_code_in;
  assign bus.dec_pc_out   = bus.iq_pc_in;

  assign bus.iss_type_out = r_type;
  assign bus.iss_rd_out   = r_rd;
  assign bus.iss_rs1_out  = r_rs1;
  assign bus.iss_rs2_out  = r_rs2;
  assign bus.iss_imm_out  = r_imm;
  assign bus.iss_pc_out   = r_pc;
  assign bus.iss_pred_out = r_pred;
  assign bus.iss_tag_out  = bus.rob_tag_in;

  // Results that are fully known at issue time go straight into the ROB.
  assign bus.rob_ready_res_out = w_is_direct;
  always_comb begin
    bus.rob_res_out = 32'd0;
    case (r_op)
      c_op_lui:   bus.rob_res_out = r_imm;
      c_op_auipc: bus.rob_res_out = r_pc + r_imm;
      c_op_jal:   bus.rob_res_out = r_pc + 32'd4;
      default:    bus.rob_res_out = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef ISSUE_STAT_EN
  logic [31:0] r_stat_issued;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_fire) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if (w_hold_v & bus.rdy_in & ~bus.flush_in & ~w_fire) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign bus.stat_issued_out = r_stat_issued;
  assign bus.stat_stall_out  = r_stat_stall;
`else
  assign bus.stat_issued_out = 32'd0;
  assign bus.stat_stall_out  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scheduler
//  Description : Directed self-checking bench for issue_scheduler. A small
//                behavioural RV32I decoder closes the decoder loop; every
//                expected value below is worked out by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

`ifdef ISSUE_STAT_EN
  localparam bit c_stat = 1'b1;
`else
  localparam bit c_stat = 1'b0;
`endif

  localparam logic [31:0] c_addi  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] c_add   = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] c_lw    = 32'h0000_A103; // lw   x2,0(x1)
  localparam logic [31:0] c_auipc = 32'h0000_1097; // auipc x1,1
  localparam logic [31:0] c_jal   = 32'h0080_00EF; // jal  x1,8
  localparam logic [31:0] c_lui   = 32'h1234_50B7; // lui  x1,0x12345
  localparam logic [31:0] c_beq   = 32'h0020_8463; // beq  x1,x2,8

  logic clk_in;
  logic rst_in;
  int   checks;
  int   failures;

  issue_scheduler_if #(.OPE_W(6), .REGN_W(6), .ROB_W(4)) bus ();

  issue_scheduler #(
    .OPE_W(6), .REGN_W(6), .ROB_W(4), .EMPTY_TYPE(0)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.master)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Behavioural decoder: type codes 1..9, 0 for anything unknown.
  always_comb begin
    logic [31:0] c;
    c = bus.iq_code_in;
    bus.dec_type_in = 6'd0;
    bus.dec_rd_in   = {1'b0, c[11:7]};
    bus.dec_rs1_in  = {1'b0, c[19:15]};
    bus.dec_rs2_in  = 6'd32;
    bus.dec_imm_in  = 32'd0;
    case (c[6:0])
      7'h37: begin bus.dec_type_in = 6'd1; bus.dec_rs1_in = 6'd32; bus.dec_imm_in = {c[31:12], 12'd0}; end
      7'h17: begin bus.dec_type_in = 6'd2; bus.dec_rs1_in = 6'd32; bus.dec_imm_in = {c[31:12], 12'd0}; end
      7'h6F: begin bus.dec_type_in = 6'd3; bus.dec_rs1_in = 6'd32;
                   bus.dec_imm_in = {{12{c[31]}}, c[19:12], c[20], c[30:21], 1'b0}; end
      7'h67: begin bus.dec_type_in = 6'd4; bus.dec_imm_in = {{20{c[31]}}, c[31:20]}; end
      7'h63: begin bus.dec_type_in = 6'd5; bus.dec_rd_in = 6'd32; bus.dec_rs2_in = {1'b0, c[24:20]};
                   bus.dec_imm_in = {{20{c[31]}}, c[7], c[30:25], c[11:8], 1'b0}; end
      7'h03: begin bus.dec_type_in = 6'd6; bus.dec_imm_in = {{20{c[31]}}, c[31:20]}; end
      7'h23: begin bus.dec_type_in = 6'd7; bus.dec_rd_in = 6'd32; bus.dec_rs2_in = {1'b0, c[24:20]};
                   bus.dec_imm_in = {{20{c[31]}}, c[31:25], c[11:7]}; end
      7'h13: begin bus.dec_type_in = 6'd8; bus.dec_imm_in = {{20{c[31]}}, c[31:20]}; end
      7'h33: begin bus.dec_type_in = 6'd9; bus.dec_rs2_in = {1'b0, c[24:20]}; end
      default: begin bus.dec_type_in = 6'd0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_in = 1'b0;
    bus.rdy_in = 1'b1;       bus.flush_in = 1'b0;
    bus.iq_valid_in = 1'b0;  bus.iq_code_in = 32'd0;
    bus.iq_pc_in = 32'd0;    bus.iq_pred_in = 1'b0;
    bus.rob_ready_in = 1'b1; bus.rob_tag_in = 4'd3;
    bus.rs_ready_in = 1'b1;  bus.lsb_ready_in = 1'b1;

    // ---------------- reset state
    #2;
    chk("rst_alloc",   bus.rob_alloc_out, 0);
    chk("rst_rs",      bus.rs_issue_out, 0);
    chk("rst_illegal", bus.illegal_out, 0);
    chk("rst_imm",     bus.iss_imm_out, 0);
    chk("rst_pc",      bus.iss_pc_out, 0);
    chk("rst_type",    bus.iss_type_out, 0);
    chk("rst_pop",     bus.iq_pop_out, 0);
    chk("rst_issued",  bus.stat_issued_out, 0);
    chk("rst_stall",   bus.stat_stall_out, 0);
    tick(); tick();
    rst_in = 1'b1;

    // ---------------- back-to-back ADDI, ADD
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_addi; bus.iq_pc_in = 32'h0; bus.iq_pred_in = 1'b1;
    #1;
    chk("addi_pop",    bus.iq_pop_out, 1);
    chk("dec_code",    bus.dec_code_out, c_addi);
    chk("dec_pc",      bus.dec_pc_out, 32'h0);
    chk("empty_alloc", bus.rob_alloc_out, 0);
    tick();
    bus.iq_code_in = c_add; bus.iq_pc_in = 32'h4; bus.iq_pred_in = 1'b0;
    #1;
    chk("addi_rs",     bus.rs_issue_out, 1);
    chk("addi_alloc",  bus.rob_alloc_out, 1);
    chk("addi_lsb",    bus.lsb_issue_out, 0);
    chk("addi_imm",    bus.iss_imm_out, 5);
    chk("addi_rd",     bus.iss_rd_out, 1);
    chk("addi_rs1",    bus.iss_rs1_out, 0);
    chk("addi_rs2",    bus.iss_rs2_out, 32);
    chk("addi_type",   bus.iss_type_out, 8);
    chk("addi_tag",    bus.iss_tag_out, 3);
    chk("addi_pred",   bus.iss_pred_out, 1);
    chk("addi_pc",     bus.iss_pc_out, 0);
    chk("addi_rdyres", bus.rob_ready_res_out, 0);
    chk("add_pop",     bus.iq_pop_out, 1);
    tick();
    bus.iq_valid_in = 1'b0; bus.rob_tag_in = 4'd4;
    #1;
    chk("add_rs",      bus.rs_issue_out, 1);
    chk("add_tag",     bus.iss_tag_out, 4);
    chk("add_rd",      bus.iss_rd_out, 3);
    chk("add_rs1",     bus.iss_rs1_out, 1);
    chk("add_rs2",     bus.iss_rs2_out, 2);
    chk("add_type",    bus.iss_type_out, 9);
    chk("add_pc",      bus.iss_pc_out, 4);
    chk("add_pred",    bus.iss_pred_out, 0);
    chk("idle_pop",    bus.iq_pop_out, 0);
    tick();
    #1;
    chk("drain_alloc", bus.rob_alloc_out, 0);
    chk("drain_rs",    bus.rs_issue_out, 0);
    chk("stat_iss2",   bus.stat_issued_out, c_stat ? 32'd2 : 32'd0);

    // ---------------- LW under LSB back-pressure
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_lw; bus.iq_pc_in = 32'h8; bus.lsb_ready_in = 1'b0;
    #1;
    chk("lw_pop",      bus.iq_pop_out, 1);
    tick();
    bus.iq_code_in = c_addi; bus.iq_pc_in = 32'hC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_stall_lsb",   bus.lsb_issue_out, 0);
      chk("lw_stall_alloc", bus.rob_alloc_out, 0);
      chk("lw_stall_pop",   bus.iq_pop_out, 0);
      tick();
    end
    bus.lsb_ready_in = 1'b1;
    #1;
    chk("lw_lsb",      bus.lsb_issue_out, 1);
    chk("lw_alloc",    bus.rob_alloc_out, 1);
    chk("lw_rs",       bus.rs_issue_out, 0);
    chk("lw_type",     bus.iss_type_out, 6);
    chk("lw_rd",       bus.iss_rd_out, 2);
    chk("lw_rs1",      bus.iss_rs1_out, 1);
    chk("lw_stall3",   bus.stat_stall_out, c_stat ? 32'd3 : 32'd0);
    chk("lw_next_pop", bus.iq_pop_out, 1);
    tick();
    bus.iq_valid_in = 1'b0;
    #1;
    chk("lw_once",     bus.lsb_issue_out, 0);
    chk("addi2_rs",    bus.rs_issue_out, 1);
    chk("addi2_pc",    bus.iss_pc_out, 32'hC);
    tick();

    // ---------------- direct-result instructions
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_auipc; bus.iq_pc_in = 32'h100;
    #1;
    tick();
    bus.iq_code_in = c_jal; bus.iq_pc_in = 32'h200;
    #1;
    chk("auipc_alloc", bus.rob_alloc_out, 1);
    chk("auipc_rs",    bus.rs_issue_out, 0);
    chk("auipc_lsb",   bus.lsb_issue_out, 0);
    chk("auipc_rdy",   bus.rob_ready_res_out, 1);
    chk("auipc_res",   bus.rob_res_out, 32'h1100);
    chk("auipc_pop",   bus.iq_pop_out, 1);
    tick();
    bus.iq_code_in = c_lui; bus.iq_pc_in = 32'h300;
    #1;
    chk("jal_alloc",   bus.rob_alloc_out, 1);
    chk("jal_rs",      bus.rs_issue_out, 0);
    chk("jal_rdy",     bus.rob_ready_res_out, 1);
    chk("jal_res",     bus.rob_res_out, 32'h204);
    tick();
    bus.iq_valid_in = 1'b0;
    #1;
    chk("lui_alloc",   bus.rob_alloc_out, 1);
    chk("lui_res",     bus.rob_res_out, 32'h1234_5000);
    tick();

    // ---------------- flush of a stalled BEQ
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_beq; bus.iq_pc_in = 32'h400; bus.rs_ready_in = 1'b0;
    #1;
    chk("beq_pop",     bus.iq_pop_out, 1);
    tick();
    bus.iq_code_in = c_addi; bus.iq_pc_in = 32'h404;
    #1;
    chk("beq_rs",      bus.rs_issue_out, 0);
    chk("beq_alloc",   bus.rob_alloc_out, 0);
    chk("beq_pop_hold", bus.iq_pop_out, 0);
    chk("beq_rdyres",  bus.rob_ready_res_out, 0);
    tick();
    bus.flush_in = 1'b1; bus.rs_ready_in = 1'b1;
    #1;
    chk("flush_rs",    bus.rs_issue_out, 0);
    chk("flush_alloc", bus.rob_alloc_out, 0);
    chk("flush_pop",   bus.iq_pop_out, 0);
    tick();
    bus.flush_in = 1'b0;
    #1;
    chk("postfl_alloc", bus.rob_alloc_out, 0);
    chk("postfl_pop",  bus.iq_pop_out, 1);
    tick();
    bus.iq_valid_in = 1'b0;
    #1;
    chk("postfl_rs",   bus.rs_issue_out, 1);
    chk("postfl_pc",   bus.iss_pc_out, 32'h404);
    chk("stat_iss7",   bus.stat_issued_out, c_stat ? 32'd7 : 32'd0);
    chk("stat_stall4", bus.stat_stall_out, c_stat ? 32'd4 : 32'd0);
    tick();

    // ---------------- illegal instruction behind a held one
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_addi; bus.iq_pc_in = 32'h500;
    #1;
    tick();
    bus.iq_code_in = 32'h0; bus.iq_pc_in = 32'h504;
    #1;
    chk("ill_prior_rs", bus.rs_issue_out, 1);
    chk("ill_pop",     bus.iq_pop_out, 1);
    chk("ill_pre",     bus.illegal_out, 0);
    tick();
    bus.iq_code_in = c_addi; bus.iq_pc_in = 32'h508;
    #1;
    chk("ill_nolatch", bus.iss_pc_out, 32'h500);
    for (int i = 0; i < 3; i++) begin
      chk("ill_flag",  bus.illegal_out, 1);
      chk("ill_nopop", bus.iq_pop_out, 0);
      chk("ill_alloc", bus.rob_alloc_out, 0);
      tick();
      #1;
    end
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    #1;
    chk("ill_flush",   bus.illegal_out, 1);
    chk("ill_pop2",    bus.iq_pop_out, 0);
    chk("stat_iss9",   bus.stat_issued_out, c_stat ? 32'd9 : 32'd0);
    bus.iq_valid_in = 1'b0;
    #1;
    rst_in = 1'b0;
    #1;
    chk("ill_async_rst", bus.illegal_out, 0);
    chk("rst_iss_clr", bus.stat_issued_out, 0);
    #2;
    rst_in = 1'b1;
    tick();

    // ---------------- rdy freeze and async reset while held
    bus.iq_valid_in = 1'b1; bus.iq_code_in = c_addi; bus.iq_pc_in = 32'h600;
    #1;
    chk("frz_pop0",    bus.iq_pop_out, 1);
    tick();
    bus.iq_pc_in = 32'h604; bus.rdy_in = 1'b0; bus.flush_in = 1'b1;
    #1;
    chk("frz_alloc",   bus.rob_alloc_out, 0);
    chk("frz_rs",      bus.rs_issue_out, 0);
    chk("frz_pop",     bus.iq_pop_out, 0);
    tick();
    bus.flush_in = 1'b0;
    #1;
    chk("frz_alloc2",  bus.rob_alloc_out, 0);
    chk("frz_pop2",    bus.iq_pop_out, 0);
    chk("frz_pc",      bus.iss_pc_out, 32'h600);
    chk("frz_stall",   bus.stat_stall_out, 0);
    chk("frz_issued",  bus.stat_issued_out, 0);
    tick();
    bus.rdy_in = 1'b1;
    #1;
    chk("thaw_rs",     bus.rs_issue_out, 1);
    chk("thaw_alloc",  bus.rob_alloc_out, 1);
    chk("thaw_pc",     bus.iss_pc_out, 32'h600);
    chk("thaw_pop",    bus.iq_pop_out, 1);
    tick();
    bus.iq_valid_in = 1'b0;
    #1;
    chk("held_alloc",  bus.rob_alloc_out, 1);
    chk("held_pc",     bus.iss_pc_out, 32'h604);
    chk("held_issued", bus.stat_issued_out, c_stat ? 32'd1 : 32'd0);
    #1;
    rst_in = 1'b0;
    #1;
    chk("arst_alloc",  bus.rob_alloc_out, 0);
    chk("arst_rs",     bus.rs_issue_out, 0);
    chk("arst_pc",     bus.iss_pc_out, 0);
    chk("arst_issued", bus.stat_issued_out, 0);
    #2;
    rst_in = 1'b1;
    tick();
    #1;
    chk("post_alloc",  bus.rob_alloc_out, 0);
    chk("post_pop",    bus.iq_pop_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sequences the combinational RV32I instruction decoder between the instruction queue and the back end.
- Pops one instruction, presents it to the decoder, and latches the decoded fields into a one-entry hold register.
- Dispatches the held instruction to the ROB plus the RS (ALU/branch/JALR) or the LSB (loads/stores) under per-unit back-pressure.
- Sits in the Issue stage; handles mispredict flush, illegal-instruction stop and rdy freeze.

Parameters:
OPE_W, 6, width of decoded instruction-type code
REGN_W, 6, register-number width; value 32 = "no register"
ROB_W, 4, ROB tag width
EMPTY_TYPE, 0, type code the decoder emits for unrecognised instructions

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes all state
flush_in  in  1  mispredict/redirect flush
iq_valid_in  in  1  queue head valid
iq_code_in  in  32  queue head instruction word
iq_pc_in  in  32  queue head PC
iq_pred_in  in  1  queue head predicted-taken bit
iq_pop_out  out  1  pop strobe to queue
dec_code_out  out  32  to decoder, combinationally equal to iq_code_in
dec_pc_out  out  32  to decoder, combinationally equal to iq_pc_in
dec_type_in  in  OPE_W  decoder type
dec_rd_in, dec_rs1_in, dec_rs2_in  in  REGN_W each  decoder register fields
dec_imm_in  in  32  decoder immediate
rob_ready_in  in  1  ROB has a free entry
rob_tag_in  in  ROB_W  tag of next ROB entry
rs_ready_in  in  1  RS has a free slot
lsb_ready_in  in  1  LSB has a free slot
rob_alloc_out  out  1  ROB allocate strobe
rs_issue_out  out  1  RS write strobe
lsb_issue_out  out  1  LSB write strobe
iss_type_out  out  OPE_W  held type
iss_rd_out, iss_rs1_out, iss_rs2_out  out  REGN_W each  held register fields
iss_imm_out, iss_pc_out  out  32 each  held immediate and PC
iss_pred_out  out  1  held prediction bit
iss_tag_out  out  ROB_W  rob_tag_in passed through
rob_ready_res_out  out  1  result already known at allocate
rob_res_out  out  32  precomputed result
illegal_out  out  1  sticky illegal-instruction flag
stat_issued_out, stat_stall_out  out  32 each  statistics counters

Behaviour:
- Reset (rst_in low, async): hold_v=0, illegal_out=0, all strobes 0, held fields 0, stat counters 0.
- Hold register states: EMPTY (hold_v=0), HELD (hold_v=1), STOP (illegal_out=1, terminal until reset).
- Class decode from held opcode bits [6:0]:
  - MEM: 0x03 or 0x23.
  - DIRECT: 0x37, 0x17, 0x6F.
  - RS: everything else.
- fire = hold_v & rdy_in & ~flush_in & rob_ready_in & (MEM ? lsb_ready_in : DIRECT ? 1 : rs_ready_in).
- Readies are level "not full" status signals, never handshake-dependent; strobes are combinational from fire.
- Strobes:
  - rob_alloc_out = fire.
  - rs_issue_out = fire & RS.
  - lsb_issue_out = fire & MEM.
  - DIRECT never writes RS/LSB.
- rob_ready_res_out = DIRECT. rob_res_out:
  - LUI: imm.
  - AUIPC: pc+imm, mod 2^32.
  - JAL: pc+4.
  - Otherwise 0.
- iq_pop_out = rdy_in & ~flush_in & ~illegal_out & iq_valid_in & (~hold_v | fire).
- On pop, latch code, pc, pred and all dec_* fields at the edge. Latency 1: popped in cycle t, dispatchable in t+1. Sustained throughput 1 instruction/cycle.
- Illegal: if at pop dec_type_in==EMPTY_TYPE, do not latch the instruction; set illegal_out at that edge; popping stops permanently. Any held valid instruction still dispatches.
- flush_in: highest priority. No pop, no fire that cycle; hold_v clears at the edge. illegal_out is unaffected.
- rdy_in low: no pop, no fire, all state frozen. flush_in is ignored while rdy_in is low.
- Simultaneous fire and pop: the new instruction replaces the held one at the same edge, with no bubble.
- Reset asserted mid-dispatch: strobes drop asynchronously and the held instruction is discarded.

Optional Feature:
- Macro ISSUE_STAT_EN.
- Defined:
  - stat_issued_out increments on every fire.
  - stat_stall_out increments each cycle with hold_v & rdy_in & ~flush_in & ~fire.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are constant 0 and no counter flops exist.

Test Plan:
- Back-to-back ADDI x1,x0,5 (0x00500093) then ADD, all readies 1 -> pops on consecutive cycles; rs_issue_out high in cycles t+1 and t+2; iss_imm_out=5, iss_tag_out tracks rob_tag_in.
- LW 0x0000A103 with lsb_ready_in=0 for 3 cycles -> no strobes and no further pop; stat_stall_out=3 if enabled; when lsb_ready_in=1, lsb_issue_out and rob_alloc_out pulse once.
- AUIPC 0x00001097 at pc 0x100 -> rob_alloc_out=1, rs/lsb strobes 0, rob_ready_res_out=1, rob_res_out=0x1100; JAL at pc 0x200 gives rob_res_out=0x204.
- Held BEQ with rs_ready_in=0, then flush_in pulse -> no strobe; hold_v=0 next cycle; next pop occurs only after flush_in deasserts.
- Code 0x00000000 at queue head -> not latched; illegal_out=1; iq_pop_out stays 0 forever; the prior held instruction still issues.
- rdy_in=0 for 2 cycles mid-stream, plus async reset asserted while HELD -> state frozen while rdy_in low; reset clears hold_v and illegal_out immediately.
